// File: rtl/wfg_mem_pkg.sv
// Shared types for the waveform-generator memory arbiter.
// Bank select, widths, Wishbone FSM states and bank ownership.
package wfg_mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int DATA_W     = 32;
  localparam int BANK_BIT   = 9;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WR_ACK,
    RD_WAIT,
    RD_ACK
  } wb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_WB,
    OWN_STREAM
  } owner_t;

endpackage

// File: rtl/wfg_mem_bank_port.sv
// One SRAM bank: grant decision between Wishbone and stream,
// then macro pin mux driven from the chosen owner.
module wfg_mem_bank_port
  import wfg_mem_pkg::*;
(
  input  logic                  wb_req,
  input  logic                  st_req,
  input  logic                  wb_prio,
  input  logic                  wb_we,
  input  logic [MEM_ADDR_W-1:0] wb_addr,
  input  logic [MEM_ADDR_W-1:0] st_addr,
  input  logic [3:0]            wb_sel,
  input  logic [DATA_W-1:0]     wb_dat,
  output owner_t                owner,
  output logic                  conflict,
  output logic                  csb,
  output logic                  web,
  output logic [3:0]            wmask,
  output logic [MEM_ADDR_W-1:0] addr,
  output logic [DATA_W-1:0]     din
);

  always_comb begin
    conflict = wb_req & st_req;
    owner    = OWN_NONE;
    if (conflict)
      owner = wb_prio ? OWN_WB : OWN_STREAM;
    else if (wb_req)
      owner = OWN_WB;
    else if (st_req)
      owner = OWN_STREAM;
  end

  always_comb begin
    csb   = 1'b1;
    web   = 1'b1;
    wmask = 4'hF;
    addr  = '0;
    din   = wb_dat;
    unique case (owner)
      OWN_WB: begin
        csb   = 1'b0;
        web   = ~wb_we;
        wmask = wb_sel;
        addr  = wb_addr;
      end
      OWN_STREAM: begin
        csb  = 1'b0;
        addr = st_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wfg_mem_arbiter.sv
// Two-bank SRAM arbiter: Wishbone slave vs. waveform stream reads.
// ARB_STATS_EN adds a saturating same-bank conflict counter.
module wfg_mem_arbiter
  import wfg_mem_pkg::*;
#(
  parameter int WB_MAX_WAIT = 4
`ifdef ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        io_wbs_clk,
  input  logic        io_wbs_rst,
  input  logic        io_wbs_cyc,
  input  logic        io_wbs_stb,
  input  logic        io_wbs_we,
  input  logic [31:0] io_wbs_adr,
  input  logic [3:0]  io_wbs_sel,
  input  logic [31:0] io_wbs_datwr,
  output logic [31:0] io_wbs_datrd,
  output logic        io_wbs_ack,
  input  logic        stream_req,
  input  logic [9:0]  stream_addr,
  output logic        stream_gnt,
  output logic        stream_rvalid,
  output logic [31:0] stream_rdata,
  output logic        csb_mem0,
  output logic        web_mem0,
  output logic [3:0]  wmask_mem0,
  output logic [8:0]  addr_mem0,
  output logic [31:0] din_mem0,
  input  logic [31:0] dout_mem0,
  output logic        csb_mem1,
  output logic        web_mem1,
  output logic [3:0]  wmask_mem1,
  output logic [8:0]  addr_mem1,
  output logic [31:0] din_mem1,
  input  logic [31:0] dout_mem1
`ifdef ARB_STATS_EN
  , output logic [CNT_W-1:0] conflict_cnt
`endif
);

  wb_state_t state_q, state_d;
  owner_t    own0, own1;
  logic      conf0, conf1;

  logic [2:0]  wait_q, wait_d;
  logic        wb_bank_q, wb_bank_d;
  logic [31:0] datrd_q, datrd_d;
  logic        st_v1_q, st_v1_d;
  logic        st_b1_q, st_b1_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic [9:0] wb_word;
  logic       wb_bank, st_bank;
  logic       wb_req, st_req, wb_prio;
  logic       wb_gnt, wb_lost;
  logic       unused_adr;

  assign wb_word    = io_wbs_adr[11:2];
  assign wb_bank    = wb_word[BANK_BIT];
  assign st_bank    = stream_addr[BANK_BIT];
  assign unused_adr = ^{io_wbs_adr[31:12], io_wbs_adr[1:0]};

  // Requests are masked during reset so nothing reaches the macros.
  assign wb_req  = ~io_wbs_rst & io_wbs_cyc & (state_q == REQ);
  assign st_req  = ~io_wbs_rst & stream_req;
  assign wb_prio = (wait_q == 3'(WB_MAX_WAIT));

  wfg_mem_bank_port u_bank0 (
    .wb_req  (wb_req & ~wb_bank),
    .st_req  (st_req & ~st_bank),
    .wb_prio (wb_prio),
    .wb_we   (io_wbs_we),
    .wb_addr (wb_word[MEM_ADDR_W-1:0]),
    .st_addr (stream_addr[MEM_ADDR_W-1:0]),
    .wb_sel  (io_wbs_sel),
    .wb_dat  (io_wbs_datwr),
    .owner   (own0),
    .conflict(conf0),
    .csb     (csb_mem0),
    .web     (web_mem0),
    .wmask   (wmask_mem0),
    .addr    (addr_mem0),
    .din     (din_mem0)
  );

  wfg_mem_bank_port u_bank1 (
    .wb_req  (wb_req & wb_bank),
    .st_req  (st_req & st_bank),
    .wb_prio (wb_prio),
    .wb_we   (io_wbs_we),
    .wb_addr (wb_word[MEM_ADDR_W-1:0]),
    .st_addr (stream_addr[MEM_ADDR_W-1:0]),
    .wb_sel  (io_wbs_sel),
    .wb_dat  (io_wbs_datwr),
    .owner   (own1),
    .conflict(conf1),
    .csb     (csb_mem1),
    .web     (web_mem1),
    .wmask   (wmask_mem1),
    .addr    (addr_mem1),
    .din     (din_mem1)
  );

  assign wb_gnt     = (own0 == OWN_WB) | (own1 == OWN_WB);
  assign stream_gnt = (own0 == OWN_STREAM) | (own1 == OWN_STREAM);
  assign wb_lost    = (conf0 | conf1) & ~wb_gnt;

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (io_wbs_cyc & io_wbs_stb) state_d = REQ;
      REQ: begin
        if (!io_wbs_cyc)  state_d = IDLE;
        else if (wb_gnt)  state_d = io_wbs_we ? WR_ACK : RD_WAIT;
      end
      WR_ACK:  state_d = IDLE;
      RD_WAIT: state_d = RD_ACK;
      RD_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io_wbs_ack = (state_q == WR_ACK) | (state_q == RD_ACK);
  end

  always_comb begin
    wait_d = wait_q;
    if (wb_gnt || state_d != REQ)
      wait_d = '0;
    else if (wb_lost && !wb_prio)
      wait_d = wait_q + 3'd1;
    wb_bank_d = wb_gnt ? wb_bank : wb_bank_q;
    datrd_d   = datrd_q;
    if (state_q == RD_WAIT)
      datrd_d = wb_bank_q ? dout_mem1 : dout_mem0;
    st_v1_d  = stream_gnt;
    st_b1_d  = st_bank;
    rvalid_d = st_v1_q;
    rdata_d  = rdata_q;
    if (st_v1_q)
      rdata_d = st_b1_q ? dout_mem1 : dout_mem0;
  end

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      wait_q    <= '0;
      wb_bank_q <= 1'b0;
      datrd_q   <= '0;
      st_v1_q   <= 1'b0;
      st_b1_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wait_q    <= wait_d;
      wb_bank_q <= wb_bank_d;
      datrd_q   <= datrd_d;
      st_v1_q   <= st_v1_d;
      st_b1_q   <= st_b1_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign io_wbs_datrd  = datrd_q;
  assign stream_rvalid = rvalid_q;
  assign stream_rdata  = rdata_q;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((conf0 | conf1) && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule
